// File: rtl/reg_sched_pkg.sv
// Shared constants for the register writeback scheduler: register file geometry
// and the writeback requester identifiers used by the arbiter.
package reg_sched_pkg;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins immediately; on contention
// the requester not granted last wins. Priority moves only when a grant is issued.
module rr_arb2
  import reg_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ID of the requester that wins the next contended cycle
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt         = '0;
      gnt[ptr_q]  = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[REQ_ALU]) begin
      ptr_d = REQ_MEM;
    end else if (gnt[REQ_MEM]) begin
      ptr_d = REQ_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Register writeback scheduler: issue scoreboard with hazard stall, ALU/load
// writeback arbitration and a one-cycle registered register-file write port.
module reg_wb_sched
  import reg_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_src1,
  input  logic [ADDR_W-1:0] iss_src2,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] r3_addr,
  output logic [DATA_W-1:0] r3_din,
  output logic              r3_wr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W-1:0]   r3_addr_q;
  logic [DATA_W-1:0]   r3_din_q;
  logic                r3_wr_q;
  logic [1:0]          req, gnt;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                iss_acc;

  always_comb begin
    req          = '0;
    req[REQ_ALU] = alu_valid;
    req[REQ_MEM] = mem_valid;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign mem_ready = gnt[REQ_MEM];

  assign iss_stall = iss_valid &
                     (busy_q[iss_src1] | busy_q[iss_src2] | busy_q[iss_dst]);
  assign iss_acc   = iss_valid & ~iss_stall;

  always_comb begin
    wb_addr = alu_addr;
    wb_data = alu_data;
    if (gnt[REQ_MEM]) begin
      wb_addr = mem_addr;
      wb_data = mem_data;
    end
  end

  // Clear from the committing write first so a same-edge issue to that register wins
  always_comb begin
    busy_d = busy_q;
    if (r3_wr_q) begin
      busy_d[r3_addr_q] = 1'b0;
    end
    if (iss_acc && (iss_dst != '0)) begin
      busy_d[iss_dst] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      r3_wr_q   <= 1'b0;
      r3_addr_q <= '0;
      r3_din_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      r3_wr_q <= (|gnt) && (wb_addr != '0);
      if (|gnt) begin
        r3_addr_q <= wb_addr;
        r3_din_q  <= wb_data;
      end
    end
  end

  assign r3_addr = r3_addr_q;
  assign r3_din  = r3_din_q;
  assign r3_wr   = r3_wr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Self-checking bench for reg_wb_sched: directed scenarios plus a randomised
// issue/writeback run against a behavioural scoreboard/arbitration model.
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_src1, iss_src2, iss_dst;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  r3_addr;
  logic [31:0] r3_din;
  logic        r3_wr;
  logic [31:0] busy;

  always #5 clk = ~clk;

  reg_wb_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_src1  (iss_src1),
    .iss_src2  (iss_src2),
    .iss_dst   (iss_dst),
    .iss_stall (iss_stall),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .r3_addr   (r3_addr),
    .r3_din    (r3_din),
    .r3_wr     (r3_wr),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending-write set, who gets preference on contention,
  // and the write the register file sees next.
  logic [31:0] m_busy;
  bit          m_alu_prio;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_din;

  bit s_stall, s_ar, s_mr;
  bit acc_alu, acc_mem, acc_iss;
  bit counting;
  int iss_cnt[32];
  int wr_cnt[32];
  int pend[$];

  task automatic model_reset();
    m_busy     = '0;
    m_alu_prio = 1'b1;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_din      = '0;
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic cycle();
    bit e_stall, e_ar, e_mr;
    #3;
    e_stall = iss_valid && (m_busy[iss_src1] || m_busy[iss_src2] || m_busy[iss_dst]);
    e_ar    = alu_valid && (!mem_valid || m_alu_prio);
    e_mr    = mem_valid && (!alu_valid || !m_alu_prio);
    s_stall = iss_stall;
    s_ar    = alu_ready;
    s_mr    = mem_ready;
    chk("iss_stall", {31'b0, iss_stall}, {31'b0, e_stall});
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, e_ar});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, e_mr});
    chk("one_grant", {31'b0, alu_ready & mem_ready}, 32'd0);

    acc_alu = e_ar;
    acc_mem = e_mr;
    acc_iss = iss_valid && !e_stall;
    if (m_wr) m_busy[m_addr] = 1'b0;
    if (acc_iss && iss_dst != 0) begin
      m_busy[iss_dst] = 1'b1;
      if (counting) iss_cnt[iss_dst]++;
    end
    if (e_ar || e_mr) begin
      m_addr     = e_ar ? alu_addr : mem_addr;
      m_din      = e_ar ? alu_data : mem_data;
      m_wr       = (m_addr != 0);
      m_alu_prio = e_mr;
    end else begin
      m_wr = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("r3_wr", {31'b0, r3_wr}, {31'b0, m_wr});
    chk("r3_addr", {27'b0, r3_addr}, {27'b0, m_addr});
    chk("r3_din", r3_din, m_din);
    chk("busy", busy, m_busy);
    if (counting && r3_wr === 1'b1) wr_cnt[r3_addr]++;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_src1 = 0; iss_src2 = 0; iss_dst = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    counting = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r3_wr", {31'b0, r3_wr}, 32'd0);
    chk("rst_r3_addr", {27'b0, r3_addr}, 32'd0);
    chk("rst_r3_din", r3_din, 32'd0);
    chk("rst_busy", busy, 32'd0);
    rst_n = 1;

    // RAW hazard on r5 resolved by an ALU writeback
    iss_valid = 1; iss_src1 = 1; iss_src2 = 2; iss_dst = 5;
    cycle();
    chk("s1_busy5", busy, 32'h0000_0020);
    iss_src1 = 5; iss_src2 = 0; iss_dst = 6;
    alu_valid = 1; alu_addr = 5; alu_data = 32'h0000_00AA;
    cycle();
    chk("s1_stall_grant", {31'b0, s_stall}, 32'd1);
    chk("s1_alu_rdy", {31'b0, s_ar}, 32'd1);
    chk("s1_wr", {31'b0, r3_wr}, 32'd1);
    chk("s1_addr", {27'b0, r3_addr}, 32'd5);
    chk("s1_din", r3_din, 32'h0000_00AA);
    alu_valid = 0;
    cycle();
    chk("s1_stall_wr", {31'b0, s_stall}, 32'd1);
    chk("s1_busy_clr", busy, 32'd0);
    cycle();
    chk("s1_unstall", {31'b0, s_stall}, 32'd0);
    chk("s1_busy6", busy, 32'h0000_0040);
    iss_valid = 0;
    mem_valid = 1; mem_addr = 6; mem_data = 32'h66;
    cycle();
    mem_valid = 0;
    cycle();

    // Contention: grants alternate starting with the ALU
    alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
    mem_valid = 1; mem_addr = 4; mem_data = 32'h44;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("s2_alu_gnt", {31'b0, s_ar}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("s2_mem_gnt", {31'b0, s_mr}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("s2_wr", {31'b0, r3_wr}, 32'd1);
      chk("s2_addr", {27'b0, r3_addr}, (k % 2 == 0) ? 32'd3 : 32'd4);
    end
    alu_valid = 0; mem_valid = 0;
    cycle();
    chk("s2_idle_wr", {31'b0, r3_wr}, 32'd0);
    chk("s2_hold_addr", {27'b0, r3_addr}, 32'd4);
    chk("s2_hold_din", r3_din, 32'h44);
    chk("s2_busy", busy, 32'd0);

    // Register 0: never tracked, writeback accepted but not written
    iss_valid = 1; iss_src1 = 0; iss_src2 = 0; iss_dst = 0;
    cycle();
    chk("s3_busy", busy, 32'd0);
    iss_valid = 0;
    alu_valid = 1; alu_addr = 0; alu_data = 32'h55;
    cycle();
    chk("s3_rdy", {31'b0, s_ar}, 32'd1);
    chk("s3_wr", {31'b0, r3_wr}, 32'd0);
    alu_valid = 0;

    // Same-edge clear and set of r7 (write to an idle register)
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    cycle();
    alu_valid = 0;
    chk("s4_wr", {31'b0, r3_wr}, 32'd1);
    iss_valid = 1; iss_src1 = 0; iss_src2 = 0; iss_dst = 7;
    cycle();
    chk("s4_accept", {31'b0, s_stall}, 32'd0);
    chk("s4_busy7", busy, 32'h0000_0080);
    iss_valid = 0;
    mem_valid = 1; mem_addr = 7; mem_data = 32'h78;
    cycle();
    mem_valid = 0;
    cycle();
    chk("s4_busy_clr", busy, 32'd0);

    // Reset in flight: pending write and busy bits dropped at once
    for (int r = 4; r < 8; r++) begin
      iss_valid = 1; iss_src1 = 0; iss_src2 = 0; iss_dst = 5'(r);
      cycle();
    end
    iss_valid = 0;
    alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    cycle();
    alu_valid = 0;
    chk("s5_pre_wr", {31'b0, r3_wr}, 32'd1);
    chk("s5_pre_busy", busy, 32'h0000_00F0);
    rst_n = 0;
    #1;
    model_reset();
    chk("s5_rst_wr", {31'b0, r3_wr}, 32'd0);
    chk("s5_rst_busy", busy, 32'd0);
    chk("s5_rst_ardy", {31'b0, alu_ready}, 32'd0);
    chk("s5_rst_mrdy", {31'b0, mem_ready}, 32'd0);
    @(posedge clk);
    #1;
    alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
    rst_n = 1;
    cycle();
    chk("s5_first_alu", {31'b0, s_ar}, 32'd1);
    chk("s5_first_mem", {31'b0, s_mr}, 32'd0);
    alu_valid = 0;
    cycle();
    mem_valid = 0;
    cycle();

    // Randomised run: bench acts as decoder and both execution units
    rst_n = 0;
    idle_inputs();
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    counting = 1;
    for (int i = 0; i < 10000; i++) begin
      iss_valid = ($urandom_range(0, 99) < 60);
      iss_src1  = 5'($urandom_range(0, 31));
      iss_src2  = 5'($urandom_range(0, 31));
      iss_dst   = 5'($urandom_range(0, 31));
      if (!alu_valid) begin
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          alu_valid = 1; alu_addr = 5'(pend.pop_front()); alu_data = $urandom;
        end else if ($urandom_range(0, 63) == 0) begin
          alu_valid = 1; alu_addr = 0; alu_data = $urandom;
        end
      end
      if (!mem_valid) begin
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          mem_valid = 1; mem_addr = 5'(pend.pop_front()); mem_data = $urandom;
        end else if ($urandom_range(0, 63) == 0) begin
          mem_valid = 1; mem_addr = 0; mem_data = $urandom;
        end
      end
      cycle();
      if (acc_alu) alu_valid = 0;
      if (acc_mem) mem_valid = 0;
      if (acc_iss && iss_dst != 0) pend.push_back(int'(iss_dst));
    end
    iss_valid = 0;
    for (int i = 0; i < 500 && (pend.size() > 0 || alu_valid || mem_valid); i++) begin
      if (!alu_valid && pend.size() > 0) begin
        alu_valid = 1; alu_addr = 5'(pend.pop_front()); alu_data = $urandom;
      end
      if (!mem_valid && pend.size() > 0) begin
        mem_valid = 1; mem_addr = 5'(pend.pop_front()); mem_data = $urandom;
      end
      cycle();
      if (acc_alu) alu_valid = 0;
      if (acc_mem) mem_valid = 0;
    end
    chk("drain_left", 32'(pend.size()) + {31'b0, alu_valid} + {31'b0, mem_valid}, 32'd0);
    alu_valid = 0; mem_valid = 0;
    cycle();
    chk("final_busy", busy, 32'd0);
    for (int r = 0; r < 32; r++) begin
      chk("wb_count", 32'(wr_cnt[r]), 32'(iss_cnt[r]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_sched.md
REG_WB_SCHED -- requirements
Module: reg_wb_sched

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk and rst_n.
REQ-002 Ports SHALL be as listed, clock and reset first:
  clk        in   1   system clock, rising edge
  rst_n      in   1   asynchronous active-low reset
  iss_valid  in   1   decoder requests issue of one instruction
  iss_src1   in   5   source register 1 of issuing instruction
  iss_src2   in   5   source register 2 of issuing instruction
  iss_dst    in   5   destination register (0 = no write)
  iss_stall  out  1   issue blocked this cycle (combinational)
  alu_valid  in   1   ALU writeback request
  alu_addr   in   5   ALU writeback register
  alu_data   in   32  ALU writeback data
  alu_ready  out  1   ALU request accepted this cycle
  mem_valid  in   1   load writeback request
  mem_addr   in   5   load writeback register
  mem_data   in   32  load writeback data
  mem_ready  out  1   load request accepted this cycle
  r3_addr    out  5   register-file write address (registered)
  r3_din     out  32  register-file write data (registered)
  r3_wr      out  1   register-file write enable (registered)
  busy       out  32  scoreboard: bit n = write to register n pending

Function
REQ-003 The module SHALL keep a 32-bit scoreboard; busy[0] SHALL read 0 at all times.
REQ-004 iss_stall SHALL be 1 when iss_valid=1 and any of busy[iss_src1], busy[iss_src2] or busy[iss_dst] is 1; otherwise 0.
REQ-005 An issue SHALL be accepted when iss_valid=1 and iss_stall=0; at the next edge busy[iss_dst] SHALL be set, unless iss_dst=0.
REQ-006 Only one writeback SHALL be granted per cycle; alu_ready and mem_ready SHALL never both be 1.
REQ-007 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not granted last; the pointer SHALL update only on a grant; after reset the ALU SHALL have priority.
REQ-008 With only one requester valid, that requester SHALL be granted in the same cycle (ready combinational on valid and pointer).
REQ-009 A requester SHALL hold valid, addr and data stable until ready=1; the module SHALL not buffer ungranted requests.
REQ-010 A grant SHALL load r3_addr/r3_din at the next edge and set r3_wr=1 for exactly one cycle; latency from grant to r3_wr = 1 cycle.
REQ-011 With no grant, r3_wr SHALL be 0 the next cycle; r3_addr/r3_din SHALL hold their last values.
REQ-012 A granted writeback to register 0 SHALL be accepted (ready=1) but SHALL produce r3_wr=0.
REQ-013 busy[r3_addr] SHALL clear at the edge ending the cycle in which r3_wr=1, the same edge at which the register file commits; dependent issue unstalls the following cycle.
REQ-014 If a clear and a set target the same register at one edge, the set SHALL win (busy stays 1).
REQ-015 A writeback to a register whose busy bit is 0 SHALL still be written; the scoreboard SHALL remain 0 (no underflow or error).

Reset
REQ-016 While rst_n=0: busy=0, r3_wr=0, r3_addr=0, r3_din=0, round-robin pointer = ALU-first; alu_ready, mem_ready and iss_stall SHALL be 0 whenever their valid inputs are 0.
REQ-017 Reset asserted mid-operation SHALL discard any pending write in the output register (r3_wr=0 immediately) and clear all busy bits.
REQ-018 After rst_n rises, the first grant SHALL be possible on the first rising clk edge.

Structure
REQ-019 Register count (32), address width (5), data width (32) and requester IDs (ALU=0, MEM=1) SHALL be constants in a shared package reg_sched_pkg.
REQ-020 The two-way round-robin arbiter SHALL be a sub-module rr_arb2 (inputs req[1:0], output gnt[1:0], internal pointer); scoreboard and output register SHALL stay in reg_wb_sched.

Verification
REQ-021 The bench SHALL cover:
  - Issue dst=5, then issue src1=5 -> iss_stall=1 until ALU writeback addr=5 data=0x0000_00AA yields r3_wr=1, r3_addr=5, r3_din=0xAA; stall=0 the following cycle.
  - alu_valid and mem_valid held 4 cycles (addr 3/4) -> grants alternate ALU, MEM, ALU, MEM; r3_wr=1 each cycle from the 2nd.
  - Issue dst=0 -> busy stays 0; writeback addr=0 -> ready=1, r3_wr=0.
  - r3_wr clears busy[7] while a new issue dst=7 is accepted at the same edge -> busy[7]=1 afterwards.
  - rst_n low with r3_wr=1 and busy=0x0000_00F0 -> r3_wr=0 and busy=0 at once; first grant after release is to ALU.
  - Randomised issue/writeback for 10k cycles -> every issued dst sees exactly one r3_wr; no cycle with both readies high.
